uart_tx_serializer: RTL

- Downstream stage of the game-status/event payload senders: consumes the byte stream (`iniciar_envio` + data byte) emitted by the payload controller and shifts it out on the FPGA UART TX pin.
- Frame format is 8N1 or 8N2: start bit, 8 data bits LSB first, stop bit(s), idle high.
- Drives `uart_ocupado` back upstream as the byte-level flow-control signal.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_counter.sv | 38 +++
 rtl/uart_tx_serializer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the TX serializer (and the future RX block).
//   uart_state_e : frame FSM states
//   DATA_BITS    : payload bits per frame
//   LINE_IDLE    : idle/stop line level
//   START_LEVEL  : start bit line level
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_counter.sv
// ---------------------------------------------------------------------------
// uart_baud_counter
// Counts clock cycles within one bit period (0..CLKS_PER_BIT-1) and wraps.
//   i_clock    : system clock
//   i_reset    : synchronous active-high reset
//   i_clear    : hold the count at zero
//   i_enable   : advance the count
//   o_bit_done : one-cycle pulse in the last cycle of a bit period
// ---------------------------------------------------------------------------
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_done
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last  = (r_count == LAST);
    assign o_bit_done = i_enable && w_at_last;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            // Wrap at the bit boundary so the next bit starts at zero.
            r_count <= w_at_last ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// Shifts bytes out on the UART TX pin as 8N1 / 8N2 frames, LSB first.
//   clock         : system clock
//   reset         : synchronous active-high reset (truncates a frame)
//   iniciar_envio : send request, accepted only while idle
//   dado_entrada  : byte to send, latched in the accept cycle
//   uart_ocupado  : high while a frame is in progress
//   tx            : registered serial line, idle high
//   byte_enviado  : one-cycle pulse in the first idle cycle after a frame
// ---------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int STOP_BITS  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar_envio,
    input  logic [7:0] dado_entrada,
    output logic       uart_ocupado,
    output logic       tx,
    output logic       byte_enviado
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_serializer: CLKS_PER_BIT must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_e r_state,    w_state_next;
    logic [7:0]  r_shift,    w_shift_next;
    logic [2:0]  r_bit_idx,  w_bit_idx_next;
    logic        r_stop_cnt, w_stop_cnt_next;
    logic        r_tx,       w_tx_next;
    logic        r_done,     w_done_next;
    logic        w_bit_done;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_clear    (r_state == IDLE),
        .i_enable   (r_state != IDLE),
        .o_bit_done (w_bit_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= LINE_IDLE;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_tx       <= w_tx_next;
            r_done     <= w_done_next;
        end
    end

    // tx is computed one cycle ahead here so the pin itself is a flop.
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_stop_cnt_next = r_stop_cnt;
        w_tx_next       = r_tx;
        w_done_next     = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_tx_next = LINE_IDLE;
                if (iniciar_envio) begin
                    w_state_next    = START;
                    w_shift_next    = dado_entrada;
                    w_bit_idx_next  = '0;
                    w_stop_cnt_next = 1'b0;
                    w_tx_next       = START_LEVEL;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_state_next = DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        w_state_next = STOP;
                        w_tx_next    = LINE_IDLE;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        // Next bit is the one that lands in bit 0 after the shift.
                        w_tx_next      = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_stop_cnt_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = LINE_IDLE;
            end
        endcase
    end

    assign uart_ocupado = (r_state != IDLE);
    assign tx           = r_tx;
    assign byte_enviado = r_done;

endmodule
